ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter HAZARD_EN, default 1: 1 enables load-use stall detection; 0 never stalls.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 id_instr  in  32  instruction in ID stage: op=[31:26], rs=[25:21], rt=[20:16], funct=[5:0].
REQ-005 id_valid  in  1  id_instr holds a real instruction; 0 means decode as bubble.
REQ-006 ex_flush  in  1  branch taken in EX this cycle; the instruction in ID is wrong-path.
REQ-007 pc_write  out  1  PC load enable, combinational.
REQ-008 if_id_write  out  1  IF/ID register load enable, combinational.
REQ-009 id_jump  out  1  j in ID, combinational.
REQ-010 ex_alu_op  out  2  registered ALUOp for the EX-stage ALU-control decoder.
REQ-011 ex_funct  out  6  registered funct field, paired with ex_alu_op.
REQ-012 ex_ctrl  out  7  registered {alu_src, reg_dst, branch, mem_read, mem_write, mem_to_reg, reg_write}.
REQ-013 mem_ctrl  out  4  registered {mem_read, mem_write, mem_to_reg, reg_write}.
REQ-014 wb_ctrl  out  2  registered {mem_to_reg, reg_write}.
REQ-015 ex_illegal  out  1  registered; instruction now in EX had an undefined opcode.

Function
REQ-016 Decode (ID, combinational) SHALL produce ALUOp, funct and 7 control bits:
- R-type 000000: ALUOp=10, reg_dst=1, reg_write=1.
- lw 100011: ALUOp=00, alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1.
- sw 101011: ALUOp=00, alu_src=1, mem_write=1.
- beq 000100: ALUOp=01, branch=1.
- addi 001000: ALUOp=00, alu_src=1, reg_write=1.
- ori 001101: ALUOp=11, alu_src=1, reg_write=1.
- j 000010: id_jump=1, all control bits 0.
REQ-017 Any other opcode SHALL decode as illegal: all control bits 0, ALUOp=00.
REQ-018 funct SHALL pass through unchanged for R-type and be forced to 000000 for all other opcodes.
REQ-019 id_valid=0 SHALL decode as bubble: all control bits 0, ALUOp=00, funct=0, illegal=0, id_jump=0.
REQ-020 ID/EX register SHALL load the decode result each cycle (latency 1 cycle ID->EX). It holds ex_alu_op, ex_funct, ex_ctrl, ex_illegal and an internal ex_rt copy.
REQ-021 EX/MEM SHALL load the mem subset of ex_ctrl each cycle; MEM/WB SHALL load the wb subset of mem_ctrl each cycle (latency 2 cycles ID->MEM, 3 cycles ID->WB).
REQ-022 Load-use hazard, when HAZARD_EN=1: asserted when ex_ctrl.mem_read=1, ex_rt!=0, and ex_rt equals ID rs, or equals ID rt for R-type/sw/beq.
REQ-023 On hazard: pc_write=0, if_id_write=0, ID/EX loads a bubble; EX/MEM and MEM/WB advance normally; stall lasts exactly 1 cycle.
REQ-024 ex_flush=1 SHALL force ID/EX to load a bubble and hold pc_write=1, if_id_write=1.
REQ-025 If ex_flush and a hazard occur in the same cycle, flush wins: no stall.
REQ-026 id_jump SHALL be 0 while ex_flush=1.
REQ-027 No hazard and no flush: pc_write=1, if_id_write=1.

Reset
REQ-028 While rst_n=0 at a clock edge, all pipeline registers SHALL clear to 0: ex_alu_op=00, ex_funct=0, ex_ctrl=0, mem_ctrl=0, wb_ctrl=0, ex_illegal=0, ex_rt=0.
REQ-029 Reset mid-stall SHALL discard the stall; combinational outputs follow the cleared state (pc_write=1).

Structure
REQ-030 A shared package SHALL hold the opcode constants, ALUOp encodings (00 add, 01 branch, 10 R-type, 11 ori), and the control-bundle bit positions.
REQ-031 Decode SHALL be one sub-module, ctrl_decode (combinational); hazard logic and the three pipeline registers remain in ctrl_pipe.

Verification
REQ-032 rst_n=0 for 2 cycles with id_valid=1 and an lw instruction -> all registered outputs 0 and pc_write=1.
REQ-033 add (op 000000, funct 100000):
- cycle+1: ex_alu_op=10, ex_funct=100000, ex_ctrl=0100001.
- cycle+3: wb_ctrl=01.
REQ-034 lw rt=5, then add rs=5:
- one cycle with pc_write=0, if_id_write=0, ex_ctrl=0.
- add reaches EX one cycle later.
REQ-035 ex_flush=1 in the same cycle as a load-use hazard -> pc_write=1, ID/EX bubble, no stall.
REQ-036 Opcode 111111 -> next cycle ex_illegal=1 and ex_ctrl=0; j -> id_jump=1 and next cycle ex_ctrl=0.
REQ-037 HAZARD_EN=0 with the REQ-034 sequence -> pc_write stays 1 throughout.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - opcodes, ALUOp encodings and control-bundle layout
package ctrl_pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_ORI    = 2'b11
  } alu_op_e;

  // ex_ctrl = {alu_src, reg_dst, branch, mem_read, mem_write, mem_to_reg, reg_write}
  localparam int CTRL_ALU_SRC    = 6;
  localparam int CTRL_REG_DST    = 5;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_MEM_READ   = 3;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_REG_WRITE  = 0;

  typedef struct packed {
    alu_op_e     alu_op;
    logic [5:0]  funct;
    logic [6:0]  ctrl;
    logic        illegal;
    logic        jump;
  } dec_t;

endpackage

// File: rtl/ctrl_pipe_if.sv
// rtl/ctrl_pipe_if.sv - ID-stage inputs and pipeline control outputs
interface ctrl_pipe_if;

  logic [31:0] id_instr;
  logic        id_valid;
  logic        ex_flush;
  logic        pc_write;
  logic        if_id_write;
  logic        id_jump;
  logic [1:0]  ex_alu_op;
  logic [5:0]  ex_funct;
  logic [6:0]  ex_ctrl;
  logic [3:0]  mem_ctrl;
  logic [1:0]  wb_ctrl;
  logic        ex_illegal;

  modport master (
    output id_instr, id_valid, ex_flush,
    input  pc_write, if_id_write, id_jump, ex_alu_op, ex_funct,
           ex_ctrl, mem_ctrl, wb_ctrl, ex_illegal
  );

  modport slave (
    input  id_instr, id_valid, ex_flush,
    output pc_write, if_id_write, id_jump, ex_alu_op, ex_funct,
           ex_ctrl, mem_ctrl, wb_ctrl, ex_illegal
  );

endinterface

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational ID-stage main decoder
module ctrl_decode
  import ctrl_pipe_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  output dec_t        dec_o
);

  logic [5:0] op;
  assign op = instr_i[31:26];

  always_comb begin
    dec_o = '0;
    if (valid_i) begin
      case (op)
        OP_RTYPE: begin
          dec_o.alu_op                = ALU_RTYPE;
          dec_o.funct                 = instr_i[5:0];
          dec_o.ctrl[CTRL_REG_DST]    = 1'b1;
          dec_o.ctrl[CTRL_REG_WRITE]  = 1'b1;
        end
        OP_LW: begin
          dec_o.ctrl[CTRL_ALU_SRC]    = 1'b1;
          dec_o.ctrl[CTRL_MEM_READ]   = 1'b1;
          dec_o.ctrl[CTRL_MEM_TO_REG] = 1'b1;
          dec_o.ctrl[CTRL_REG_WRITE]  = 1'b1;
        end
        OP_SW: begin
          dec_o.ctrl[CTRL_ALU_SRC]    = 1'b1;
          dec_o.ctrl[CTRL_MEM_WRITE]  = 1'b1;
        end
        OP_BEQ: begin
          dec_o.alu_op                = ALU_BRANCH;
          dec_o.ctrl[CTRL_BRANCH]     = 1'b1;
        end
        OP_ADDI: begin
          dec_o.ctrl[CTRL_ALU_SRC]    = 1'b1;
          dec_o.ctrl[CTRL_REG_WRITE]  = 1'b1;
        end
        OP_ORI: begin
          dec_o.alu_op                = ALU_ORI;
          dec_o.ctrl[CTRL_ALU_SRC]    = 1'b1;
          dec_o.ctrl[CTRL_REG_WRITE]  = 1'b1;
        end
        OP_J:    dec_o.jump    = 1'b1;
        default: dec_o.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - control pipeline: decode, load-use stall, flush, ID/EX/MEM/WB regs
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int HAZARD_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  ctrl_pipe_if.slave  bus
);

  dec_t       dec;
  alu_op_e    ex_alu_op_q, ex_alu_op_d;
  logic [5:0] ex_funct_q, ex_funct_d;
  logic [6:0] ex_ctrl_q, ex_ctrl_d;
  logic       ex_illegal_q, ex_illegal_d;
  logic [4:0] ex_rt_q, ex_rt_d;
  logic [3:0] mem_ctrl_q;
  logic [1:0] wb_ctrl_q;

  logic [5:0] id_op;
  logic [4:0] id_rs, id_rt;
  logic       uses_rt, load_use, stall, bubble;

  ctrl_decode u_decode (
    .instr_i (bus.id_instr),
    .valid_i (bus.id_valid),
    .dec_o   (dec)
  );

  assign id_op = bus.id_instr[31:26];
  assign id_rs = bus.id_instr[25:21];
  assign id_rt = bus.id_instr[20:16];
  assign uses_rt = (id_op == OP_RTYPE) || (id_op == OP_SW) || (id_op == OP_BEQ);

  // A bubble in ID has no source operands, so it never waits on a load.
  assign load_use = (HAZARD_EN != 0) && bus.id_valid && ex_ctrl_q[CTRL_MEM_READ] &&
                    (ex_rt_q != 5'd0) &&
                    ((ex_rt_q == id_rs) || (uses_rt && (ex_rt_q == id_rt)));
  assign stall  = load_use && !bus.ex_flush;
  assign bubble = stall || bus.ex_flush;

  always_comb begin
    ex_alu_op_d  = ALU_ADD;
    ex_funct_d   = '0;
    ex_ctrl_d    = '0;
    ex_illegal_d = 1'b0;
    ex_rt_d      = '0;
    if (!bubble) begin
      ex_alu_op_d  = dec.alu_op;
      ex_funct_d   = dec.funct;
      ex_ctrl_d    = dec.ctrl;
      ex_illegal_d = dec.illegal;
      ex_rt_d      = bus.id_valid ? id_rt : 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_alu_op_q  <= ALU_ADD;
      ex_funct_q   <= '0;
      ex_ctrl_q    <= '0;
      ex_illegal_q <= 1'b0;
      ex_rt_q      <= '0;
      mem_ctrl_q   <= '0;
      wb_ctrl_q    <= '0;
    end else begin
      ex_alu_op_q  <= ex_alu_op_d;
      ex_funct_q   <= ex_funct_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_illegal_q <= ex_illegal_d;
      ex_rt_q      <= ex_rt_d;
      mem_ctrl_q   <= ex_ctrl_q[CTRL_MEM_READ:CTRL_REG_WRITE];
      wb_ctrl_q    <= mem_ctrl_q[CTRL_MEM_TO_REG:CTRL_REG_WRITE];
    end
  end

  assign bus.pc_write    = !stall;
  assign bus.if_id_write = !stall;
  assign bus.id_jump     = dec.jump && !bus.ex_flush;
  assign bus.ex_alu_op   = ex_alu_op_q;
  assign bus.ex_funct    = ex_funct_q;
  assign bus.ex_ctrl     = ex_ctrl_q;
  assign bus.mem_ctrl    = mem_ctrl_q;
  assign bus.wb_ctrl     = wb_ctrl_q;
  assign bus.ex_illegal  = ex_illegal_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - directed bench for ctrl_pipe with and without hazard detection
module tb_ctrl_pipe;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_failed;

  ctrl_pipe_if bus_a ();
  ctrl_pipe_if bus_b ();

  ctrl_pipe #(.HAZARD_EN(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  ctrl_pipe #(.HAZARD_EN(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic valid, input logic flush);
    bus_a.id_instr = instr;
    bus_a.id_valid = valid;
    bus_a.ex_flush = flush;
    bus_b.id_instr = instr;
    bus_b.id_valid = valid;
    bus_b.ex_flush = flush;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [5:0] funct);
    return {6'b000000, rs, rt, 5'd3, 5'd0, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {op, rs, rt, 16'h0025};
  endfunction

  localparam logic [31:0] NOP = 32'h0;

  initial begin
    n_tests  = 0;
    n_failed = 0;

    // reset held two cycles with a valid lw in ID
    rst_n = 1'b0;
    drive(itype(6'b100011, 5'd0, 5'd5), 1'b1, 1'b0);
    tick();
    tick();
    check("rst_ex_ctrl",   {25'd0, bus_a.ex_ctrl},    32'h0);
    check("rst_ex_alu_op", {30'd0, bus_a.ex_alu_op},  32'h0);
    check("rst_ex_funct",  {26'd0, bus_a.ex_funct},   32'h0);
    check("rst_mem_ctrl",  {28'd0, bus_a.mem_ctrl},   32'h0);
    check("rst_wb_ctrl",   {30'd0, bus_a.wb_ctrl},    32'h0);
    check("rst_illegal",   {31'd0, bus_a.ex_illegal}, 32'h0);
    check("rst_pc_write",  {31'd0, bus_a.pc_write},   32'h1);
    check("rst_if_id",     {31'd0, bus_a.if_id_write}, 32'h1);
    rst_n = 1'b1;
    drive(NOP, 1'b0, 1'b0);
    tick(); tick(); tick();

    // add flows through EX, MEM, WB
    drive(rtype(5'd1, 5'd2, 6'b100000), 1'b1, 1'b0);
    check("add_pc_write", {31'd0, bus_a.pc_write}, 32'h1);
    tick();
    drive(NOP, 1'b0, 1'b0);
    check("add_ex_alu_op", {30'd0, bus_a.ex_alu_op}, 32'h2);
    check("add_ex_funct",  {26'd0, bus_a.ex_funct},  32'h20);
    check("add_ex_ctrl",   {25'd0, bus_a.ex_ctrl},   32'b0100001);
    tick();
    check("add_mem_ctrl",  {28'd0, bus_a.mem_ctrl},  32'b0001);
    check("bubble_ex_ctrl", {25'd0, bus_a.ex_ctrl},  32'h0);
    tick();
    check("add_wb_ctrl",   {30'd0, bus_a.wb_ctrl},   32'b01);

    // lw rt=5 followed by add rs=5: one stall cycle
    drive(itype(6'b100011, 5'd0, 5'd5), 1'b1, 1'b0);
    tick();
    check("lw_ex_ctrl", {25'd0, bus_a.ex_ctrl}, 32'b1001011);
    drive(rtype(5'd5, 5'd6, 6'b100000), 1'b1, 1'b0);
    check("lu_pc_write",   {31'd0, bus_a.pc_write},    32'h0);
    check("lu_if_id",      {31'd0, bus_a.if_id_write}, 32'h0);
    check("nohz_pc_write", {31'd0, bus_b.pc_write},    32'h1);
    tick();
    check("lu_ex_bubble",  {25'd0, bus_a.ex_ctrl},  32'h0);
    check("lu_mem_ctrl",   {28'd0, bus_a.mem_ctrl}, 32'b1011);
    check("lu_pc_release", {31'd0, bus_a.pc_write}, 32'h1);
    check("nohz_ex_ctrl",  {25'd0, bus_b.ex_ctrl},  32'b0100001);
    check("nohz_pc_write2", {31'd0, bus_b.pc_write}, 32'h1);
    tick();
    drive(NOP, 1'b0, 1'b0);
    check("lu_add_in_ex",  {25'd0, bus_a.ex_ctrl},   32'b0100001);
    check("lu_add_alu_op", {30'd0, bus_a.ex_alu_op}, 32'h2);
    tick();

    // rt match stalls for R-type, not for addi; ex_rt=0 never stalls
    drive(itype(6'b100011, 5'd0, 5'd5), 1'b1, 1'b0);
    tick();
    drive(rtype(5'd1, 5'd5, 6'b100010), 1'b1, 1'b0);
    check("lu_rt_rtype", {31'd0, bus_a.pc_write}, 32'h0);
    drive(itype(6'b001000, 5'd0, 5'd5), 1'b1, 1'b0);
    check("lu_rt_addi",  {31'd0, bus_a.pc_write}, 32'h1);
    tick();
    drive(itype(6'b100011, 5'd0, 5'd0), 1'b1, 1'b0);
    tick();
    drive(rtype(5'd0, 5'd0, 6'b100000), 1'b1, 1'b0);
    check("lu_rt_zero",  {31'd0, bus_a.pc_write}, 32'h1);
    tick();

    // flush in the same cycle as a load-use hazard
    drive(itype(6'b100011, 5'd0, 5'd5), 1'b1, 1'b0);
    tick();
    drive(rtype(5'd5, 5'd6, 6'b100000), 1'b1, 1'b1);
    check("fl_pc_write", {31'd0, bus_a.pc_write},    32'h1);
    check("fl_if_id",    {31'd0, bus_a.if_id_write}, 32'h1);
    tick();
    drive(NOP, 1'b0, 1'b0);
    check("fl_ex_bubble", {25'd0, bus_a.ex_ctrl}, 32'h0);
    tick();

    // illegal opcode, jump, ori funct masking, beq
    drive({6'b111111, 26'h3ffffff}, 1'b1, 1'b0);
    tick();
    check("ill_flag",    {31'd0, bus_a.ex_illegal}, 32'h1);
    check("ill_ex_ctrl", {25'd0, bus_a.ex_ctrl},    32'h0);
    drive({6'b000010, 26'h0000100}, 1'b1, 1'b0);
    check("j_id_jump",   {31'd0, bus_a.id_jump},    32'h1);
    drive({6'b000010, 26'h0000100}, 1'b1, 1'b1);
    check("j_flush_jump", {31'd0, bus_a.id_jump},   32'h0);
    drive({6'b000010, 26'h0000100}, 1'b1, 1'b0);
    tick();
    check("j_ex_ctrl",   {25'd0, bus_a.ex_ctrl},    32'h0);
    check("j_illegal",   {31'd0, bus_a.ex_illegal}, 32'h0);
    drive(itype(6'b001101, 5'd1, 5'd2), 1'b1, 1'b0);
    tick();
    check("ori_alu_op",  {30'd0, bus_a.ex_alu_op},  32'h3);
    check("ori_funct",   {26'd0, bus_a.ex_funct},   32'h0);
    check("ori_ex_ctrl", {25'd0, bus_a.ex_ctrl},    32'b1000001);
    drive(itype(6'b000100, 5'd1, 5'd2), 1'b1, 1'b0);
    tick();
    check("beq_alu_op",  {30'd0, bus_a.ex_alu_op},  32'h1);
    check("beq_ex_ctrl", {25'd0, bus_a.ex_ctrl},    32'b0010000);
    drive(NOP, 1'b0, 1'b0);
    tick();

    // reset while stalled discards the stall
    drive(itype(6'b100011, 5'd0, 5'd5), 1'b1, 1'b0);
    tick();
    drive(rtype(5'd5, 5'd6, 6'b100000), 1'b1, 1'b0);
    check("rs_stall_pre", {31'd0, bus_a.pc_write}, 32'h0);
    rst_n = 1'b0;
    tick();
    check("rs_stall_pc",  {31'd0, bus_a.pc_write}, 32'h1);
    check("rs_ex_ctrl",   {25'd0, bus_a.ex_ctrl},  32'h0);
    check("rs_mem_ctrl",  {28'd0, bus_a.mem_ctrl}, 32'h0);
    rst_n = 1'b1;
    drive(NOP, 1'b0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
